fetch_stage: RTL

//  Instruction fetch stage of the RV64 core, directly upstream of decode/immgen. Holds the PC, issues

---
 rtl/riscv_pkg.sv | 12 +
 rtl/fetch_buf.sv | 63 ++++++
 rtl/fetch_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV64 core constants and fetch-stage types.
package riscv_pkg;
  localparam int          XLEN     = 64;
  localparam int          ILEN     = 32;
  localparam logic [63:0] RESET_PC = 64'h0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_buf.sv
// Instruction buffer: small synchronous FIFO of {pc, instruction} pairs with flush.
module fetch_buf #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [XLEN-1:0]           push_pc,
  input  logic [riscv_pkg::ILEN-1:0] push_inst,
  output logic                      valid,
  output logic [XLEN-1:0]           head_pc,
  output logic [riscv_pkg::ILEN-1:0] head_inst,
  output logic [CW-1:0]             count
);
  import riscv_pkg::*;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [ILEN-1:0] inst_q [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid     = (count_q != '0);
  assign count     = count_q;
  assign head_pc   = pc_q[rd_ptr];
  assign head_inst = inst_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; occupancy is governed by the pointers above.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_q[wr_ptr]   <= push_pc;
      inst_q[wr_ptr] <= push_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (count_q == CW'(DEPTH))));
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// RV64 instruction fetch: PC, memory request credit, stale-response dropping, redirect handling.
module fetch_stage #(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(riscv_pkg::RESET_PC),
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] redirect_imm,
  output logic            misalign_err
);
  import riscv_pkg::*;

  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW:0]     in_flight;
  logic [XLEN-1:0] target;
  logic            fire;
  logic            push;
  logic            pop;
  logic            redir;
  logic            dropping;

  // Credit: buffered + in-flight instructions never exceed the buffer size.
  assign in_flight      = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && (state == FETCH) && (in_flight < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr  = pc;
  assign fire           = imem_req_valid && imem_req_ready;

  assign target   = redirect_base + (redirect_imm << 1);
  assign redir    = redirect_valid && (state != HALT);
  assign dropping = (drop_cnt != '0);
  assign push     = imem_resp_valid && !dropping && !redir && (state != HALT);
  assign pop      = inst_valid && inst_ready;

  assign outstanding_nxt = outstanding + CW'(fire) - CW'(imem_resp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      resp_pc      <= RESET_PC;
      outstanding  <= '0;
      drop_cnt     <= '0;
      misalign_err <= 1'b0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redir) begin
        if (target[1]) begin
          state        <= HALT;
          misalign_err <= 1'b1;
        end else begin
          // Everything still in flight (including this cycle's fire) belongs to the old path.
          pc       <= target;
          resp_pc  <= target;
          drop_cnt <= outstanding_nxt;
          state    <= (outstanding_nxt != '0) ? FLUSH : FETCH;
        end
      end else begin
        if (fire) pc <= pc + XLEN'(4);
        if (push) resp_pc <= resp_pc + XLEN'(4);
        if (imem_resp_valid && dropping) begin
          drop_cnt <= drop_cnt - CW'(1);
          if ((state == FLUSH) && (drop_cnt == CW'(1))) state <= FETCH;
        end
      end
    end
  end

  fetch_buf #(
    .XLEN  (XLEN),
    .DEPTH (BUF_DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redir),
    .push_pc   (resp_pc),
    .push_inst (imem_resp_data),
    .valid     (inst_valid),
    .head_pc   (inst_pc),
    .head_inst (inst_data),
    .count     (count)
  );
endmodule
